// File: rtl/demux_reg_bank_pkg.sv
// demux_reg_bank_pkg: shared defaults and sizing rule for the receive-path demux.
// Flag and ack vectors are ordered bit i = channel i throughout.
package demux_reg_bank_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_N_CH   = 32;
    localparam int DEF_SEL_W  = 6;
    function automatic bit sel_w_ok(input int n_ch, input int sel_w);
        return n_ch >= 2 && n_ch <= 256 && sel_w < 31 && (1 << sel_w) >= n_ch;
    endfunction
endpackage

// File: rtl/demux_reg_bank_channel.sv
// demux_channel: one channel register with its valid and sticky overrun flags.
module demux_channel #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_ack,
    input  logic              i_clr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_ovr
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_ovr   <= 1'b0;
        end else if (i_load) begin
            o_data  <= i_din;
            o_valid <= 1'b1;
            // an ack or clear landing with the write cancels both old and new overrun
            o_ovr   <= !(i_ack || i_clr) && (o_ovr || o_valid);
        end else if (i_clr || i_ack) begin
            o_valid <= 1'b0;
            o_ovr   <= 1'b0;
        end
    end
endmodule

// File: rtl/demux_reg_bank.sv
// demux_reg_bank: registered 1-to-N demux with per-channel hold/ack, overrun,
// select-error pulse and accepted-write counter.
module demux_reg_bank
    import demux_reg_bank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_CH   = DEF_N_CH,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   bcast,
    input  logic [DATA_W-1:0]      din,
    input  logic [N_CH-1:0]        ack,
    input  logic                   clr_all,
    output logic [N_CH*DATA_W-1:0] dout,
    output logic [N_CH-1:0]        valid,
    output logic [N_CH-1:0]        ovr,
    output logic                   sel_err,
    output logic [15:0]            wr_cnt
);
    if (!sel_w_ok(N_CH, SEL_W)) begin : g_bad_params
        $error("demux_reg_bank: N_CH must be 2..256 and 2**SEL_W >= N_CH");
    end

    logic            w_sel_ok;
    logic            w_accept;
    logic [N_CH-1:0] w_load;
    logic            r_sel_err;
    logic [15:0]     r_wr_cnt;

    assign w_sel_ok = 32'(sel) < N_CH;
    assign w_accept = wr_en && (bcast || w_sel_ok);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign w_load[i] = w_accept && (bcast || 32'(sel) == i);
        demux_channel #(.DATA_W(DATA_W)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .i_load  (w_load[i]),
            .i_din   (din),
            .i_ack   (ack[i]),
            .i_clr   (clr_all),
            .o_data  (dout[i*DATA_W +: DATA_W]),
            .o_valid (valid[i]),
            .o_ovr   (ovr[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel_err <= 1'b0;
            r_wr_cnt  <= '0;
        end else begin
            r_sel_err <= wr_en && !bcast && !w_sel_ok;
            r_wr_cnt  <= r_wr_cnt + 16'(w_accept);
        end
    end

    assign sel_err = r_sel_err;
    assign wr_cnt  = r_wr_cnt;
endmodule

// File: doc/demux_reg_bank.md
Name: demux_reg_bank

Overview:
- Parametrised, registered 1-to-N demultiplexer for the serial receive path.
- Routes each incoming data word to one addressed channel register, or to all channels at once.
- Holds each word until the consumer acknowledges it, with per-channel valid and overrun flags.
- Sits between the UART byte receiver and the command/display logic. Outputs are registered and glitch-free; no combinational latching.

Parameters:
- DATA_W, 8, width of data word and of each channel register
- N_CH, 32, number of output channels (2..256)
- SEL_W, 6, selector width; must satisfy 2**SEL_W >= N_CH; wider than needed so out-of-range codes are detectable

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write strobe, one word per cycle when high
- sel  in  SEL_W  target channel index
- bcast  in  1  when high with wr_en, write all channels; sel ignored
- din  in  DATA_W  data word
- ack  in  N_CH  per-channel acknowledge; bit i clears valid[i] and ovr[i]
- clr_all  in  1  synchronous clear of all valid and ovr flags; data untouched
- dout  out  N_CH*DATA_W  flattened channel registers; channel i at bits [i*DATA_W +: DATA_W]
- valid  out  N_CH  channel holds unacknowledged data
- ovr  out  N_CH  sticky: channel was written while valid was already set
- sel_err  out  1  one-cycle pulse: wr_en with sel >= N_CH and bcast low
- wr_cnt  out  16  count of accepted writes; wraps at 0xFFFF→0

Behaviour:
- Reset (async assert, sync release): dout=0, valid=0, ovr=0, sel_err=0, wr_cnt=0.
- Latency: an accepted write at edge k appears on dout and valid after edge k.
- Accepted write: wr_en=1 and (bcast=1 or sel<N_CH).
  - Addressed channel (or every channel if bcast) loads din and sets valid.
  - Non-addressed channels hold their values.
- Overrun: write to channel i while valid[i]=1 and ack[i]=0 sets ovr[i].
  - ovr[i] stays set until ack[i] or clr_all.
  - The new data overwrites the old.
- Write and ack[i] in the same cycle:
  - Write wins: valid[i]=1, new data loaded.
  - ovr[i] is not set by this write.
  - Any previously set ovr[i] is cleared by the ack.
- ack[i] with no write to channel i: valid[i]=0, ovr[i]=0 next cycle; dout unchanged.
- clr_all: clears all valid and ovr next cycle.
  - Same cycle as a write: the written channel(s) end with valid=1, ovr=0.
- Rejected write (sel>=N_CH, bcast=0):
  - No register changes.
  - sel_err=1 for exactly the next cycle.
  - wr_cnt does not increment.
- sel_err is 0 in all other cycles.
- wr_cnt increments by 1 per accepted write; a broadcast counts as 1.
- wr_en=0: sel, din and bcast are don't-care; no state change except ack and clr_all effects.
- Reset mid-operation: all state returns to reset values immediately; the first write after release behaves as from a clean state.
- Priority per channel, highest first: reset, write, clr_all, ack, hold.

Decomposition:
- Shared header/package holds:
  - default DATA_W and N_CH
  - the SEL_W sizing rule
  - the ack/flag bit-ordering convention: bit i = channel i
- One sub-module: demux_channel.
  - Contains one DATA_W data register plus its valid and ovr flops.
  - Inputs: load, din, ack, clr.
  - The top level instantiates N_CH of them in a generate loop.
  - The top level also owns the select decode, sel_err and wr_cnt.

Test Plan:
- Reset, then write din=0xA5 sel=3 → next cycle: channel 3 dout=0xA5, valid=0x00000008, ovr=0, wr_cnt=1; all other channels 0.
- Write 0x11 then 0x22 to sel=7 on consecutive cycles with no ack → ch7=0x22, valid[7]=1, ovr[7]=1. Then ack[7] → valid[7]=0, ovr[7]=0, ch7 still 0x22.
- Write 0x5A to sel=9 with ack[9]=1 in the same cycle, valid[9] previously 1 → ch9=0x5A, valid[9]=1, ovr[9]=0.
- bcast=1, din=0x3C, sel=40 → all 32 channels=0x3C, valid=0xFFFFFFFF, sel_err=0, wr_cnt +1.
- bcast=0, sel=32 and sel=63 writes → sel_err pulses one cycle each; dout, valid and wr_cnt unchanged.
- Assert reset asynchronously mid-cycle after several writes → all outputs 0 before the next edge. Preload wr_cnt to 0xFFFF via writes, then one more write → wr_cnt=0.
